nco_iq_gen: RTL

- Parametrised successor to the 1-bit square-wave NCO: phase accumulator with a quarter-wave sine LUT that produces signed multi-bit I/Q (cos/sin) at a programmable frequency.
- Adds async reset, enable, synchronous phase clear, a phase-offset input, and a valid/ready increment-update handshake.
- The handshake supports immediate or wrap-aligned (phase-coherent) retune.
- Legacy 1-bit sin/cos square outputs are kept, so it sits in the SDR front end as a drop-in local oscillator for the mixer.

---
 rtl/nco_iq_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/nco_iq_gen.sv
// rtl/nco_iq_gen.sv - phase-accumulator NCO with quarter-wave sine LUT, signed I/Q and square outputs
// Define NCO_DITHER_EN to add LFSR phase dither below the LUT address bits.
module nco_iq_gen #(
    parameter int    ACC_W    = 64,
    parameter int    OUT_W    = 8,
    parameter int    LUT_AW   = 8,
    parameter string LUT_FILE = "nco_qsin.hex"
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    phase_clr_i,
    input  logic [ACC_W-1:0]        phase_offset_i,
    input  logic [ACC_W-1:0]        inc_data_i,
    input  logic                    inc_align_i,
    input  logic                    inc_valid_i,
    output logic                    inc_ready_o,
    output logic [ACC_W-1:0]        phase_accum_o,
    output logic signed [OUT_W-1:0] sin_out_o,
    output logic signed [OUT_W-1:0] cos_out_o,
    output logic                    sin_bit_o,
    output logic                    cos_bit_o,
    output logic                    out_valid_o
);

    localparam int LUT_N  = 1 << LUT_AW;
    localparam int FRAC_W = ACC_W - 2 - LUT_AW;

    typedef logic [OUT_W-2:0] mag_t;
    typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;

    if (ACC_W < LUT_AW + 2 || OUT_W < 2 || OUT_W > 16 || LUT_FILE == "") begin : g_param_check
        $error("nco_iq_gen: illegal parameter combination");
    end

    // Table is computed at elaboration with a Q30 Taylor series so no init file is needed.
    function automatic mag_t qsin(input int k);
        longint x, x2, term, s, amp;
        x    = (64'sd3373259426 * longint'(2 * k + 1)) / longint'(4 * LUT_N);
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int n = 1; n <= 10; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            s    = s + term;
        end
        amp = longint'((1 << (OUT_W - 1)) - 1);
        return mag_t'((amp * s + (64'sd1 <<< 29)) >>> 30);
    endfunction

    mag_t lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam mag_t VAL = qsin(k);
        assign lut[k] = VAL;
    end

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  inc_cur_q, inc_cur_d;
    logic [ACC_W-1:0]  inc_pend_q, inc_pend_d;
    logic [ACC_W-1:0]  acc_sum;
    logic              acc_carry;
    logic              wrap;

    assign {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, inc_cur_q};
    assign wrap  = enable_i & acc_carry;
    assign acc_d = phase_clr_i ? '0 : (enable_i ? acc_sum : acc_q);

    always_comb begin
        state_d     = state_q;
        inc_cur_d   = inc_cur_q;
        inc_pend_d  = inc_pend_q;
        inc_ready_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                inc_ready_o = 1'b1;
                if (inc_valid_i) begin
                    if (!inc_align_i || inc_cur_q == '0 || phase_clr_i) begin
                        inc_cur_d = inc_data_i;
                    end else begin
                        inc_pend_d = inc_data_i;
                        state_d    = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                // The wrapping add still uses the old increment; the new one lands after it.
                if (wrap || phase_clr_i) begin
                    inc_cur_d = inc_pend_q;
                    state_d   = ST_RUN;
                end
            end
        endcase
    end

    logic [ACC_W-1:0] dither;

`ifdef NCO_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    if (FRAC_W >= 16) begin : g_dith_full
        assign dither = ACC_W'(lfsr_q) << (FRAC_W - 16);
    end else if (FRAC_W > 0) begin : g_dith_part
        assign dither = ACC_W'(lfsr_q[FRAC_W-1:0]);
    end else begin : g_dith_none
        assign dither = '0;
    end
`else
    assign dither = '0;
`endif

    logic [LUT_AW+1:0]       phase_top;
    logic [1:0]              q1_q, q2_q;
    logic [LUT_AW-1:0]       a1_q;
    mag_t                    la_q, lna_q;
    logic signed [OUT_W-1:0] pos_a, pos_na, sin_d, cos_d;
    logic signed [OUT_W-1:0] sin_q, cos_q;
    logic                    sin_bit_q, cos_bit_q;
    logic [2:0]              en_q;

    assign phase_top = (LUT_AW + 2)'((acc_q + phase_offset_i + dither) >> FRAC_W);
    assign pos_a     = {1'b0, la_q};
    assign pos_na    = {1'b0, lna_q};

    always_comb begin
        sin_d = '0;
        cos_d = '0;
        case (q2_q)
            2'd0: begin sin_d = pos_a;   cos_d = pos_na;  end
            2'd1: begin sin_d = pos_na;  cos_d = -pos_a;  end
            2'd2: begin sin_d = -pos_a;  cos_d = -pos_na; end
            default: begin sin_d = -pos_na; cos_d = pos_a; end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RUN;
            acc_q      <= '0;
            inc_cur_q  <= '0;
            inc_pend_q <= '0;
            q1_q       <= '0;
            a1_q       <= '0;
            q2_q       <= '0;
            la_q       <= '0;
            lna_q      <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            sin_bit_q  <= 1'b0;
            cos_bit_q  <= 1'b0;
            en_q       <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            inc_cur_q  <= inc_cur_d;
            inc_pend_q <= inc_pend_d;
            q1_q       <= phase_top[LUT_AW+1:LUT_AW];
            a1_q       <= phase_top[LUT_AW-1:0];
            q2_q       <= q1_q;
            la_q       <= lut[a1_q];
            lna_q      <= lut[~a1_q];
            sin_q      <= sin_d;
            cos_q      <= cos_d;
            sin_bit_q  <= ~q2_q[1];
            cos_bit_q  <= ~(q2_q[1] ^ q2_q[0]);
            en_q       <= {en_q[1:0], enable_i};
        end
    end

    assign phase_accum_o = acc_q;
    assign sin_out_o     = sin_q;
    assign cos_out_o     = cos_q;
    assign sin_bit_o     = sin_bit_q;
    assign cos_bit_o     = cos_bit_q;
    assign out_valid_o   = en_q[2];

endmodule
